// File: rtl/tcb_nn_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tcb_nn_frame_ctrl
//   Sequencer in front of the TCB 121-16-10 MNIST core. It collects a
//   byte-serial pixel stream into one NPIX*PIX_W image word and offers it to
//   the core on a valid/ready handshake. CORE_LAT cycles after that handshake
//   it captures the core's class output and holds it on a result handshake
//   until the consumer takes it. It also counts accepted results and flags
//   frames whose length does not match NPIX.
//
//   Build option: FRAME_CTRL_PINGPONG_EN
//     undefined : one image buffer; pixels are accepted only in LOAD.
//     defined   : two image buffers (A/B). The next frame loads while the
//                 current one is being issued or waiting for its result.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   pix_data     pixel byte
//   pix_valid    pixel present
//   pix_ready    pixel accepted when pix_valid & pix_ready
//   pix_last     marks the final pixel of a frame
//   core_img     image to the core; pixel 0 in the most significant byte
//   core_valid   image valid to the core
//   core_ready   core accepts the image
//   core_number  class output from the core
//   res_number   registered class result
//   res_valid    result available
//   res_ready    consumer takes the result
//   frame_cnt    number of results taken by the consumer (wraps)
//   err_len      one-cycle pulse on a frame-length error
// ---------------------------------------------------------------------------
module tcb_nn_frame_ctrl #(
  parameter int NPIX     = 121,
  parameter int PIX_W    = 8,
  parameter int CORE_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic                  pix_last,
  output logic [NPIX*PIX_W-1:0] core_img,
  output logic                  core_valid,
  input  logic                  core_ready,
  input  logic [7:0]            core_number,
  output logic [7:0]            res_number,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  err_len
);

  localparam int IMG_W = NPIX * PIX_W;
  localparam int PC_W  = $clog2(NPIX + 1);
  localparam int LAT_W = $clog2(CORE_LAT + 1);

  localparam logic [PC_W-1:0]  LAST_IDX = PC_W'(NPIX - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CORE_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pix_cnt_reg, pix_cnt_next;
  logic [LAT_W-1:0]  lat_reg, lat_next;
  logic              res_valid_reg, res_valid_next;
  logic [7:0]        res_number_reg, res_number_next;
  logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic              err_len_reg, err_len_next;

  logic              pix_fire;
  logic              at_last;
  logic              frame_done;
  logic              frame_drop;
  logic              res_fire;
  logic              start_issue;
  logic [NPIX-1:0]   slot_hit;

  // -------------------------------------------------------------------------
  // Pixel counting and frame-length checking
  // -------------------------------------------------------------------------
  assign pix_fire   = pix_valid & pix_ready;
  assign at_last    = (pix_cnt_reg == LAST_IDX);
  assign frame_done = pix_fire & at_last;
  // An early pix_last throws the partial frame away.
  assign frame_drop = pix_fire & pix_last & ~at_last;
  assign res_fire   = res_valid_reg & res_ready;

  always_comb begin
    pix_cnt_next = pix_cnt_reg;
    if (pix_fire) begin
      if (at_last || pix_last) begin
        pix_cnt_next = '0;
      end else begin
        pix_cnt_next = pix_cnt_reg + 1'b1;
      end
    end
  end

  // A full-length frame without pix_last still completes but is flagged.
  assign err_len_next = frame_drop | (frame_done & ~pix_last);

  // One write strobe per byte slot of the image word.
  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_slot
      assign slot_hit[gi] = pix_fire && (pix_cnt_reg == PC_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Image buffering
  // -------------------------------------------------------------------------
`ifdef FRAME_CTRL_PINGPONG_EN
  logic [IMG_W-1:0] img_a_reg, img_a_next;
  logic [IMG_W-1:0] img_b_reg, img_b_next;
  logic [1:0]       full_reg, full_next;
  logic             load_sel_reg, load_sel_next;   // buffer being filled (0=A)
  logic             issue_sel_reg, issue_sel_next; // buffer owned by the FSM

  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_pp_wr
      assign img_a_next[(NPIX-gi)*PIX_W-1 -: PIX_W] =
        (slot_hit[gi] && !load_sel_reg) ? pix_data : img_a_reg[(NPIX-gi)*PIX_W-1 -: PIX_W];
      assign img_b_next[(NPIX-gi)*PIX_W-1 -: PIX_W] =
        (slot_hit[gi] &&  load_sel_reg) ? pix_data : img_b_reg[(NPIX-gi)*PIX_W-1 -: PIX_W];
    end
  endgenerate

  // The issuing buffer is released when its result is taken; the filled
  // buffer becomes full on its last pixel. These never target the same bit:
  // the filling buffer is empty while the issuing one is full.
  always_comb begin
    full_next      = full_reg;
    load_sel_next  = load_sel_reg;
    issue_sel_next = issue_sel_reg;
    if (res_fire) begin
      full_next[issue_sel_reg] = 1'b0;
      issue_sel_next           = ~issue_sel_reg;
    end
    if (frame_done) begin
      full_next[load_sel_reg] = 1'b1;
      load_sel_next           = ~load_sel_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      img_a_reg     <= '0;
      img_b_reg     <= '0;
      full_reg      <= '0;
      load_sel_reg  <= 1'b0;
      issue_sel_reg <= 1'b0;
    end else begin
      img_a_reg     <= img_a_next;
      img_b_reg     <= img_b_next;
      full_reg      <= full_next;
      load_sel_reg  <= load_sel_next;
      issue_sel_reg <= issue_sel_next;
    end
  end

  assign pix_ready   = ~full_reg[load_sel_reg];
  assign start_issue = full_reg[issue_sel_reg];
  assign core_img    = issue_sel_reg ? img_b_reg : img_a_reg;
`else
  logic [IMG_W-1:0] img_reg, img_next;

  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_wr
      assign img_next[(NPIX-gi)*PIX_W-1 -: PIX_W] =
        slot_hit[gi] ? pix_data : img_reg[(NPIX-gi)*PIX_W-1 -: PIX_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      img_reg <= '0;
    end else begin
      img_reg <= img_next;
    end
  end

  // Pixels only arrive in LOAD, so a completed frame issues straight away.
  assign pix_ready   = (state_reg == ST_LOAD);
  assign start_issue = frame_done;
  assign core_img    = img_reg;
`endif

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    lat_next        = lat_reg;
    res_valid_next  = res_valid_reg;
    res_number_next = res_number_reg;
    frame_cnt_next  = frame_cnt_reg;
    core_valid      = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        if (start_issue) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_valid = 1'b1;
        if (core_ready) begin
          lat_next   = LAT_LOAD;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Count 1 is the cycle core_number is valid for this image.
        if (lat_reg == LAT_ONE) begin
          res_number_next = core_number;
          res_valid_next  = 1'b1;
          state_next      = ST_HOLD;
        end else begin
          lat_next = lat_reg - 1'b1;
        end
      end
      ST_HOLD: begin
        if (res_fire) begin
          res_valid_next = 1'b0;
          frame_cnt_next = frame_cnt_reg + 1'b1;
          state_next     = ST_LOAD;
        end
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_LOAD;
      pix_cnt_reg    <= '0;
      lat_reg        <= '0;
      res_valid_reg  <= 1'b0;
      res_number_reg <= '0;
      frame_cnt_reg  <= '0;
      err_len_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pix_cnt_reg    <= pix_cnt_next;
      lat_reg        <= lat_next;
      res_valid_reg  <= res_valid_next;
      res_number_reg <= res_number_next;
      frame_cnt_reg  <= frame_cnt_next;
      err_len_reg    <= err_len_next;
    end
  end

  assign res_valid  = res_valid_reg;
  assign res_number = res_number_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign err_len    = err_len_reg;

endmodule
